// File: rtl/pc_gen.sv
// Program-counter generator for the fetch front end: sequential increment, stall,
// redirect, trap vectoring with EPC/cause capture, and a circular return-address stack.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     INSN_BYTES   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic [1:0]      cause_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_underflow_o
);

  localparam int unsigned     OFF_W     = (INSN_BYTES > 1) ? $clog2(INSN_BYTES) : 1;
  localparam int unsigned     PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned     CNT_W     = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] INC       = XLEN'(INSN_BYTES);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [1:0]      CAUSE_EXT = 2'd1;
  localparam logic [1:0]      CAUSE_MIS = 2'd2;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             uf_q, uf_d;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

  logic             push_en;
  logic             misaligned;
  logic [XLEN-1:0]  pc_inc;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

  assign misaligned = (INSN_BYTES > 1) && (redirect_target_i[OFF_W-1:0] != '0);
  assign pc_inc     = pc_q + INC;
  assign top_inc    = (top_q == PTR_MAX) ? '0 : top_q + 1'b1;
  assign top_dec    = (top_q == '0) ? PTR_MAX : top_q - 1'b1;

  // Priority chain: trap, misaligned redirect, redirect(+call), ret, stall, increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    uf_d    = 1'b0;
    push_en = 1'b0;
    if (trap_i) begin
      pc_d    = TRAP_VECTOR;
      epc_d   = pc_q;
      cause_d = CAUSE_EXT;
    end else if (redirect_valid_i && misaligned) begin
      pc_d    = TRAP_VECTOR;
      epc_d   = pc_q;
      cause_d = CAUSE_MIS;
    end else if (redirect_valid_i) begin
      pc_d = redirect_target_i;
      if (call_i) begin
        // A push on a full stack overwrites the oldest slot; count saturates.
        push_en = 1'b1;
        top_d   = top_inc;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
    end else if (ret_i && (cnt_q != '0)) begin
      pc_d  = ras_mem[top_q];
      top_d = top_dec;
      cnt_d = cnt_q - 1'b1;
    end else if (ret_i) begin
      pc_d = pc_inc;
      uf_d = 1'b1;
    end else if (!stall_i) begin
      pc_d = pc_inc;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      epc_q      <= '0;
      cause_q    <= '0;
      top_q      <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      uf_q       <= uf_d;
    end
  end

  // NOTE: stack storage is not reset; a zero count already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push_en) ras_mem[top_inc] <= pc_inc;
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = pc_valid_q;
  assign epc_o           = epc_q;
  assign cause_o         = cause_q;
  assign ras_empty_o     = empty_q;
  assign ras_full_o      = full_q;
  assign ras_underflow_o = uf_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: queue-based reference model checked every cycle,
// directed vectors with literal expectations, and an 8-bit instance for wrap-around.
module tb_pc_gen;

  localparam int unsigned D     = 4;
  localparam logic [31:0] RV    = 32'h1000;
  localparam logic [31:0] TV    = 32'h100;
  localparam logic [31:0] INC   = 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0, redirect_valid_i = 1'b0, call_i = 1'b0, ret_i = 1'b0, trap_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic [31:0] pc_o, epc_o;
  logic        pc_valid_o, ras_empty_o, ras_full_o, ras_underflow_o;
  logic [1:0]  cause_o;

  logic        rv8 = 1'b0;
  logic [7:0]  tgt8 = '0;
  logic [7:0]  pc8, epc8;
  logic        valid8, empty8, full8, uf8;
  logic [1:0]  cause8;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_uf;
  logic [1:0]  m_cause;
  logic [31:0] m_ras [$];

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .INSN_BYTES(4), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(D)) u_dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
    .redirect_target_i(redirect_target_i), .call_i(call_i), .ret_i(ret_i), .trap_i(trap_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .epc_o(epc_o), .cause_o(cause_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_underflow_o(ras_underflow_o)
  );

  pc_gen #(.XLEN(8), .INSN_BYTES(4), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h10), .RAS_DEPTH(2)) u_dut8 (
    .clk(clk), .reset(reset), .stall_i(1'b0), .redirect_valid_i(rv8),
    .redirect_target_i(tgt8), .call_i(1'b0), .ret_i(1'b0), .trap_i(1'b0),
    .pc_o(pc8), .pc_valid_o(valid8), .epc_o(epc8), .cause_o(cause8),
    .ras_empty_o(empty8), .ras_full_o(full8), .ras_underflow_o(uf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_pc    = RV;
    m_valid = 1'b0;
    m_epc   = '0;
    m_cause = 2'd0;
    m_uf    = 1'b0;
    m_ras.delete();
  endtask

  // Next architectural state from the current request, evaluated before the edge.
  task model_step();
    if (reset) begin
      model_reset();
    end else begin
      m_valid = 1'b1;
      m_uf    = 1'b0;
      if (trap_i) begin
        m_epc = m_pc; m_pc = TV; m_cause = 2'd1;
      end else if (redirect_valid_i && (redirect_target_i % INC != 0)) begin
        m_epc = m_pc; m_pc = TV; m_cause = 2'd2;
      end else if (redirect_valid_i) begin
        if (call_i) begin
          m_ras.push_back(m_pc + INC);
          if (m_ras.size() > D) m_ras.delete(0);
        end
        m_pc = redirect_target_i;
      end else if (ret_i && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else if (ret_i) begin
        m_pc = m_pc + INC; m_uf = 1'b1;
      end else if (!stall_i) begin
        m_pc = m_pc + INC;
      end
    end
  endtask

  always @(negedge clk) begin
    check("pc", pc_o, m_pc);
    check("pc_valid", pc_valid_o, m_valid);
    check("epc", epc_o, m_epc);
    check("cause", cause_o, m_cause);
    check("ras_empty", ras_empty_o, m_ras.size() == 0);
    check("ras_full", ras_full_o, m_ras.size() == D);
    check("ras_underflow", ras_underflow_o, m_uf);
  end

  task step(input logic st, input logic rv, input logic [31:0] tgt,
            input logic cl, input logic rt, input logic tr);
    stall_i = st; redirect_valid_i = rv; redirect_target_i = tgt;
    call_i = cl; ret_i = rt; trap_i = tr;
    model_step();
    @(negedge clk);
    #1;
  endtask

  task idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    idle(); idle();
    check("rst_pc", pc_o, 32'h1000);
    check("rst_valid", pc_valid_o, 32'h0);
    check("rst_empty", ras_empty_o, 32'h1);

    reset = 1'b0;
    idle(); check("seq_pc1", pc_o, 32'h1004); check("seq_valid", pc_valid_o, 32'h1);
    idle(); check("seq_pc2", pc_o, 32'h1008);
    idle(); check("seq_pc3", pc_o, 32'h100C);

    // Asynchronous reset between edges.
    reset = 1'b1; model_reset();
    #2;
    check("async_pc", pc_o, 32'h1000);
    check("async_valid", pc_valid_o, 32'h0);
    idle();
    reset = 1'b0;

    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0); check("redir_20", pc_o, 32'h20);
    repeat (3) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); check("stall_hold", pc_o, 32'h20);
    end
    step(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0); check("stall_redirect", pc_o, 32'h400);

    // Nested calls and returns.
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h90, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0); check("call3_pc", pc_o, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ret1", pc_o, 32'h94);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ret2", pc_o, 32'h54);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ret3", pc_o, 32'h14);
    check("ret_empty", ras_empty_o, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("uf_pc", pc_o, 32'h18);
    check("uf_pulse", ras_underflow_o, 32'h1);
    idle(); check("uf_clear", ras_underflow_o, 32'h0); check("uf_next_pc", pc_o, 32'h1C);

    // Overflow: five pushes into a four-entry stack.
    step(1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i <= 7; i++) step(1'b0, 1'b1, i * 32'h1000, 1'b1, 1'b0, 1'b0);
    check("ovf_full", ras_full_o, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ovf_ret_a5", pc_o, 32'h6004);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ovf_ret_a4", pc_o, 32'h5004);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ovf_ret_a3", pc_o, 32'h4004);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("ovf_ret_a2", pc_o, 32'h3004);
    check("ovf_empty", ras_empty_o, 32'h1);

    // Traps.
    step(1'b0, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("trap_pc", pc_o, 32'h100); check("trap_epc", epc_o, 32'h88); check("trap_cause", cause_o, 32'h1);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0); check("call_40", pc_o, 32'h40);
    step(1'b0, 1'b1, 32'h302, 1'b1, 1'b0, 1'b0);
    check("mis_pc", pc_o, 32'h100); check("mis_epc", epc_o, 32'h40); check("mis_cause", cause_o, 32'h2);
    check("mis_ras_kept", ras_empty_o, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); check("mis_ret", pc_o, 32'h104);
    check("mis_ret_empty", ras_empty_o, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); check("lone_call_pc", pc_o, 32'h108);
    check("lone_call_empty", ras_empty_o, 32'h1);
    step(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1);
    check("trap_wins_pc", pc_o, 32'h100); check("trap_wins_epc", epc_o, 32'h108);
    check("trap_wins_cause", cause_o, 32'h1); check("trap_wins_empty", ras_empty_o, 32'h1);

    // 8-bit wrap-around.
    rv8 = 1'b1; tgt8 = 8'hFC;
    idle(); check("wrap_fc", {24'h0, pc8}, 32'hFC);
    rv8 = 1'b0;
    idle(); check("wrap_00", {24'h0, pc8}, 32'h00); check("wrap_valid", valid8, 32'h1);
    idle(); check("wrap_04", {24'h0, pc8}, 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end. It replaces the fixed-width, increment-only PC unit and adds:
- stall
- branch/jump redirect
- trap vectoring with exception-PC capture
- misaligned-target detection
- a return-address stack (RAS) for call/return

Sits between the branch/exception logic and instruction fetch. It drives the fetch address every cycle.

## Interface
Parameters:
- XLEN, 32, address width in bits.
- INSN_BYTES, 4, instruction size in bytes. Power of two, at least 1. Also the sequential increment and the alignment granule.
- RESET_VECTOR, 0, PC value loaded on reset. XLEN bits, aligned.
- TRAP_VECTOR, 32'h100, PC value loaded on a trap. XLEN bits, aligned.
- RAS_DEPTH, 4, number of return-address stack entries, at least 1.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold the PC. Suppresses only the sequential increment.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  XLEN  destination of the redirect.
- call  in  1  push a return address. Honoured only together with an accepted redirect.
- ret  in  1  pop the RAS and jump to the popped address.
- trap  in  1  external exception request.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is meaningful.
- epc  out  XLEN  PC captured at the last trap.
- cause  out  2  cause of the last trap: 0 = none, 1 = external, 2 = misaligned redirect.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_underflow  out  1  one-cycle pulse when ret finds the RAS empty.

## Operation
- All state is registered, and all outputs come directly from registers.
- reset asserted, effective immediately and without waiting for clk:
  - pc = RESET_VECTOR, pc_valid = 0, epc = 0, cause = 0.
  - RAS count = 0, so ras_empty = 1 and ras_full = 0.
  - ras_underflow = 0.
- First rising edge after reset deasserts: pc_valid <= 1. It stays 1 until the next reset. The PC update rules below apply on that same edge.
- Next-PC priority at each rising edge, highest first:
  1. trap: pc <= TRAP_VECTOR, epc <= pc, cause <= 1.
  2. redirect_valid with redirect_target[log2(INSN_BYTES)-1:0] != 0: treated as a trap. pc <= TRAP_VECTOR, epc <= pc, cause <= 2. No RAS push. Skipped when INSN_BYTES = 1.
  3. redirect_valid, aligned target: pc <= redirect_target. If call is also high, push pc + INSN_BYTES onto the RAS.
  4. ret, RAS not empty: pc <= top entry, and the entry is popped.
  5. ret, RAS empty: pc <= pc + INSN_BYTES, and ras_underflow pulses high for one cycle.
  6. stall: pc holds.
  7. Otherwise: pc <= pc + INSN_BYTES.
- Items 1–5 override stall. Lower-priority requests in the same cycle are discarded, not queued.
- call without an accepted redirect is ignored. ret alongside a redirect or trap is ignored.
- All PC arithmetic is modulo 2^XLEN. The maximum aligned address plus INSN_BYTES wraps to 0.
- RAS is a circular buffer of RAS_DEPTH × XLEN with a top pointer and a count from 0 to RAS_DEPTH.
  - Push when full overwrites the oldest entry. Count stays RAS_DEPTH and ras_full stays 1.
  - The pop order remains newest-first.
- cause and epc hold until the next trap or reset. They are never cleared otherwise.

## Timing
- Inputs are sampled at the rising edge. The new pc is visible after that edge, so there is 1-cycle latency from request to pc.
- There is no combinational path from any input to any output.
- ras_empty and ras_full update on the same edge as the push or pop.
- ras_underflow is high for exactly the cycle following the edge that sampled the offending ret.
- reset asserted mid-operation: every output takes its reset value at once. RAS contents are lost because the count is zeroed; the entry storage need not be cleared.
- reset deasserted: pc remains RESET_VECTOR until the first edge, and it advances on that edge unless a request of priority 1–6 applies.

## Test plan
- Reset sequencing, defaults, RESET_VECTOR = 0x1000: hold reset 2 cycles, release, run 3 edges. Required: pc = 0x1000 and pc_valid = 0 during reset; then pc = 0x1004, 0x1008, 0x100C with pc_valid = 1. Assert reset asynchronously between edges: pc returns to 0x1000 before the next edge.
- Stall versus redirect: stall high for 3 cycles at pc = 0x20, then stall with redirect to 0x400 in one cycle. Required: pc holds 0x20 for 3 cycles, then becomes 0x400 (redirect wins).
- Call/return nesting, RAS_DEPTH = 4:
  - Calls at pc 0x10, 0x50, 0x90 to targets 0x50, 0x90, 0x200.
  - Then 3 rets.
  - Required: pc sequence 0x200 → 0x94 → 0x54 → 0x14; ras_empty = 1 at the end.
  - A 4th ret: pc = 0x18 and a 1-cycle ras_underflow pulse.
- RAS overflow: 5 calls pushing A1..A5 into depth 4. Required: ras_full = 1; 4 rets yield A5, A4, A3, A2; ras_empty = 1.
- Traps:
  - trap at pc = 0x88: pc = TRAP_VECTOR, epc = 0x88, cause = 1.
  - redirect to 0x302 at pc = 0x40: pc = TRAP_VECTOR, epc = 0x40, cause = 2, RAS unchanged even with call high.
  - trap with redirect in the same cycle: the trap wins.
- Wrap-around, XLEN = 8, INSN_BYTES = 4: redirect to 0xFC, then one free-running cycle. Required: pc = 0x00.
